dm_responder: RTL and testbench

//   Data-memory responder serving the MEM-stage store/load interface.

---
 rtl/dm_responder_if.sv | 28 ++
 rtl/dm_responder.sv | 135 +++++++++++++
 tb/tb_dm_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// MEM-stage data-memory request/response bundle.
// master = pipeline side, slave = memory responder.
interface dm_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_addr, req_byteen,
    output req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, stall
  );

  modport slave (
    input  req_valid, req_addr, req_byteen,
    input  req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, stall
  );
endinterface

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder with masked word writes.
// Optional store trace enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input logic          clk,
  input logic          reset_n,
  dm_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] merged;
  logic        oor;
  logic        rsp_valid;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [DEPTH];

  assign idx       = addr_q[ADDR_WIDTH+1:2];
  assign oor       = |addr_q[31:ADDR_WIDTH+2];
  assign rsp_valid = (state == RESP);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.stall     = bus.req_valid & ~rsp_valid;

  // Next state, countdown and accept/commit strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stored word with the selected lanes replaced by store data
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wd_q[8*i +: 8];
    end
  end

  // State register, request latch and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= bus.req_addr;
        be_q   <= bus.req_byteen;
        wd_q   <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q <= oor ? 32'd0 : merged;
        err_q   <= oor;
      end
    end
  end

  // Memory array is never reset; commit only fires in BUSY
  always_ff @(posedge clk) begin
    if (commit && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^addr_q[1:0];

`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q;

  // Store trace: one line per in-range write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      if (accept) pc_q <= bus.req_pc;
      if (commit && !oor && be_q != 4'd0)
        $display("%d@%h: *%h <= %h", $time, pc_q,
                 {addr_q[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: vector table, reset abort
// sequence and randomized traffic against a word-map model.
module tb_dm_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  dm_responder_if bus ();

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic [31:0] model_mem [int];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: word map, out-of-range if any byte-address bit >= 14 set
  task automatic model_apply(input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd,
                             output logic [31:0] rd, output logic err);
    int w;
    logic [31:0] cur;
    if (a >= 32'h4000) begin
      rd = 32'd0;
      err = 1'b1;
    end else begin
      w = int'(a >> 2);
      cur = model_mem.exists(w) ? model_mem[w] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
      model_mem[w] = cur;
      rd = cur;
      err = 1'b0;
    end
  endtask

  // Called at a negedge with the responder idle
  task automatic txn(input string nm, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    int n;
    bit seen;
    bus.req_addr = a;
    bus.req_byteen = be;
    bus.req_wdata = wd;
    bus.req_pc = 32'h1000 + a;
    bus.req_valid = 1'b1;
    #1;
    chk({nm, " ready@req"}, 32'(bus.req_ready), 32'd1);
    chk({nm, " stall@req"}, 32'(bus.stall), 32'd1);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) begin
        seen = 1;
      end else begin
        chk({nm, " stall@busy"}, 32'(bus.stall), 32'd1);
        chk({nm, " ready@busy"}, 32'(bus.req_ready), 32'd0);
      end
    end
    chk({nm, " latency"}, 32'(n), 32'd3);
    if (seen) begin
      chk({nm, " stall@resp"}, 32'(bus.stall), 32'd0);
      chk({nm, " ready@resp"}, 32'(bus.req_ready), 32'd0);
      chk({nm, " rdata"}, bus.rsp_rdata, er);
      chk({nm, " err"}, 32'(bus.rsp_err), 32'(ee));
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk({nm, " single pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, " ready@idle"}, 32'(bus.req_ready), 32'd1);
    chk({nm, " rdata hold"}, bus.rsp_rdata, er);
  endtask

  vec_t vecs [10];
  logic [31:0] mrd;
  logic merr;

  initial begin
    vecs[0] = '{32'h0000_0000, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h0000_0010, 4'b0000, 32'h0, 32'h1234_5678, 1'b0};
    vecs[3] = '{32'h0000_0011, 4'b0010, 32'h0000_AB00, 32'h1234_AB78, 1'b0};
    vecs[4] = '{32'h0000_0010, 4'b0000, 32'h0, 32'h1234_AB78, 1'b0};
    vecs[5] = '{32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b1};
    vecs[6] = '{32'h0000_0000, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{32'h0000_0014, 4'b1111, 32'h1122_3344, 32'h1122_3344, 1'b0};
    vecs[8] = '{32'h0000_0016, 4'b1010, 32'hAABB_CCDD, 32'hAA22_CC44, 1'b0};
    vecs[9] = '{32'h0000_0017, 4'b0000, 32'h0, 32'hAA22_CC44, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_byteen = '0;
    bus.req_wdata = '0;
    bus.req_pc = '0;
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rdata", bus.rsp_rdata, 32'd0);
    chk("reset err", 32'(bus.rsp_err), 32'd0);
    chk("reset ready", 32'(bus.req_ready), 32'd1);
    chk("reset stall", 32'(bus.stall), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      model_apply(vecs[i].addr, vecs[i].be, vecs[i].wd, mrd, merr);
      txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].be,
          vecs[i].wd, vecs[i].rd, vecs[i].err);
    end

    // Reset while BUSY aborts the pending store
    bus.req_addr = 32'h20;
    bus.req_byteen = 4'b1111;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("abort in busy", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort rdata", bus.rsp_rdata, 32'd0);
    chk("abort err", 32'(bus.rsp_err), 32'd0);
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no pulse", 32'(bus.rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    txn("abort read", 32'h20, 4'b0000, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against the word-map model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [3:0] be;
      logic [31:0] wd;
      if ($urandom_range(0, 7) == 0)
        a = $urandom | 32'h0001_0000;
      else
        a = 32'($urandom_range(0, 127));
      be = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      wd = $urandom;
      model_apply(a, be, wd, mrd, merr);
      txn($sformatf("rand%0d", i), a, be, wd, mrd, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
